// File: rtl/prio_event_pkg.sv
// prio_event_pkg
//   Shared definitions for the priority-event capture block: request code
//   width, the idle/reset code, the debounce counter width and the qualifier
//   FSM state encoding.
package prio_event_pkg;

    // Width of the encoded request code from the upstream 8-to-3 encoder.
    localparam int CODE_W = 3;

    // Code the synchronizer holds out of reset (matches an idle encoder output).
    localparam logic [CODE_W-1:0] IDLE_CODE = 3'b111;

    // Stability counter width; wide enough for DEB_CYCLES up to 15.
    localparam int CNT_W = 4;

    // Qualifier FSM. QUAL is only reachable when debouncing is compiled in.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        QUAL   = 2'd1,
        ACTIVE = 2'd2
    } qual_state_e;

endpackage

// File: rtl/prio_event_fifo.sv
// prio_event_fifo
//   Circular event queue with a sticky overflow flag.
//   Ports:
//     clk_i, rst_i      clock, asynchronous active-high reset
//     push_i, data_i    enqueue request and its payload
//     pop_i             consumer ready; a pop happens only when non-empty
//     clr_ovf_i         synchronous clear of the overflow flag
//     data_o            head entry, forced to zero while empty
//     valid_o           queue non-empty
//     count_o           current occupancy (0..DEPTH)
//     ovf_o             sticky: a push was dropped because the queue was full
module prio_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    input  logic                     clr_ovf_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     ovf_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;

    logic empty, full, do_push, do_pop, ovf_set;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign do_pop  = pop_i & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full queue
    // still lands when the consumer is draining.
    assign do_push = push_i & (~full | do_pop);
    assign ovf_set = push_i & full & ~do_pop;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        // Setting takes priority over a simultaneous clear.
        ovf_d   = ovf_set | (ovf_q & ~clr_ovf_i);
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage needs no reset: nothing is visible until count_q says so.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

    assign data_o  = empty ? '0 : mem_q[rptr_q];
    assign valid_o = ~empty;
    assign count_o = count_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/prio_event_capture.sv
// prio_event_capture
//   Captures request levels from an asynchronous 8-to-3 priority encoder
//   ({gs, y}, gs active-low), qualifies them and queues one event per newly
//   reported level.
//   Build option PRIO_EVENT_DEBOUNCE_EN: when defined, a request must stay
//   stable for DEB_CYCLES synchronized cycles before it is reported; when
//   undefined, DEB_CYCLES is ignored and any new or changed request is
//   reported on the first synchronized cycle it appears.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     y, gs           encoder code and active-low group select (async)
//     evt_code        head event code (zero while empty)
//     evt_valid       queue non-empty
//     evt_ready       consumer accepts the head event
//     evt_count       queue occupancy
//     ovf, clr_ovf    sticky overflow flag and its synchronous clear
module prio_event_capture
    import prio_event_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DEB_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CODE_W-1:0]      y,
    input  logic                   gs,
    output logic [CODE_W-1:0]      evt_code,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [$clog2(DEPTH):0] evt_count,
    output logic                   ovf,
    input  logic                   clr_ovf
);

    // Two-flop synchronizer on {gs, y}; resets to an idle encoder.
    logic [CODE_W:0] sync1_q, sync2_q;
    logic            gs_s;
    logic [CODE_W-1:0] y_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= {1'b1, IDLE_CODE};
            sync2_q <= {1'b1, IDLE_CODE};
        end else begin
            sync1_q <= {gs, y};
            sync2_q <= sync1_q;
        end
    end

    assign gs_s = sync2_q[CODE_W];
    assign y_s  = sync2_q[CODE_W-1:0];

    // code_q is the candidate while in QUAL and the reported level while
    // ACTIVE; qualification promotes the candidate without a copy.
    qual_state_e       state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              push;
    logic [CODE_W-1:0] push_code;

`ifdef PRIO_EVENT_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        push_code = code_q;
        case (state_q)
            IDLE: begin
                if (!gs_s) begin
                    state_d = QUAL;
                    code_d  = y_s;
                    cnt_d   = '0;
                end
            end
            QUAL: begin
                if (gs_s) begin
                    state_d = IDLE;
                end else if (y_s != code_q) begin
                    code_d = y_s;
                    cnt_d  = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ACTIVE;
                    push    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACTIVE: begin
                if (gs_s) begin
                    state_d = IDLE;
                end else if (y_s != code_q) begin
                    state_d = QUAL;
                    code_d  = y_s;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        push      = 1'b0;
        push_code = y_s;
        case (state_q)
            IDLE: begin
                if (!gs_s) begin
                    state_d = ACTIVE;
                    code_d  = y_s;
                    push    = 1'b1;
                end
            end
            ACTIVE: begin
                if (gs_s) begin
                    state_d = IDLE;
                end else if (y_s != code_q) begin
                    code_d = y_s;
                    push   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= IDLE_CODE;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    prio_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CODE_W)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (rst),
        .push_i    (push),
        .data_i    (push_code),
        .pop_i     (evt_ready),
        .clr_ovf_i (clr_ovf),
        .data_o    (evt_code),
        .valid_o   (evt_valid),
        .count_o   (evt_count),
        .ovf_o     (ovf)
    );

endmodule

// File: tb/tb_prio_event_capture.sv
// tb_prio_event_capture
//   Directed bench for prio_event_capture with default parameters
//   (DEPTH=4, DEB_CYCLES=4). Expected latencies and the outcome of the
//   gs-toggle sequence follow the PRIO_EVENT_DEBOUNCE_EN build setting.
module tb_prio_event_capture;

`ifdef PRIO_EVENT_DEBOUNCE_EN
    localparam int VLAT  = 2 + 4 + 1;  // input step to evt_valid
    localparam int B_CNT = 0;          // toggling gs never qualifies
    localparam int B_OVF = 0;
`else
    localparam int VLAT  = 3;
    localparam int B_CNT = 4;          // five pushes into a 4-deep queue
    localparam int B_OVF = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] y   = 3'b111;
    logic       gs  = 1'b1;
    logic       evt_ready = 1'b0;
    logic       clr_ovf   = 1'b0;
    logic [2:0] evt_code;
    logic       evt_valid;
    logic [2:0] evt_count;
    logic       ovf;

    int n_chk  = 0;
    int n_fail = 0;

    logic [2:0] drain_exp [4] = '{3'b001, 3'b010, 3'b011, 3'b110};

    always #5 clk = ~clk;

    prio_event_capture dut (
        .clk       (clk),
        .rst       (rst),
        .y         (y),
        .gs        (gs),
        .evt_code  (evt_code),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_count (evt_count),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset state, checked while reset is held.
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", 8'(evt_valid), 8'h0);
        chk("rst_count", 8'(evt_count), 8'h0);
        chk("rst_code",  8'(evt_code),  8'h0);
        chk("rst_ovf",   8'(ovf),       8'h0);
        tick(2);
        rst = 1'b0;
        tick(3);

        // Clean step gs=0, y=010 held 10 cycles, no consumer.
        gs = 1'b0; y = 3'b010;
        tick(VLAT - 1);
        chk("a_valid_early", 8'(evt_valid), 8'h0);
        tick(1);
        chk("a_valid_on_time", 8'(evt_valid), 8'h1);
        chk("a_code", 8'(evt_code), 8'h2);
        tick(10 - VLAT);
        chk("a_single_entry", 8'(evt_count), 8'h1);
        gs = 1'b1; y = 3'b111;
        tick(4);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk("a_popped_count", 8'(evt_count), 8'h0);
        chk("a_empty_code", 8'(evt_code), 8'h0);

        // gs toggling every 2 cycles for 20 cycles.
        y = 3'b011;
        for (int i = 0; i < 10; i++) begin
            gs = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(2);
        end
        gs = 1'b1; y = 3'b111;
        tick(4);
        chk("b_toggle_count", 8'(evt_count), 8'(B_CNT));
        chk("b_toggle_ovf", 8'(ovf), 8'(B_OVF));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);

        // Five distinct codes 000..100 with no consumer.
        for (int c = 0; c < 5; c++) begin
            gs = 1'b0; y = 3'(c);
            tick(8);
        end
        gs = 1'b1; y = 3'b111;
        tick(4);
        chk("c_full_count", 8'(evt_count), 8'h4);
        chk("c_ovf_set", 8'(ovf), 8'h1);
        chk("c_head", 8'(evt_code), 8'h0);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        chk("c_ovf_cleared", 8'(ovf), 8'h0);
        chk("c_count_kept", 8'(evt_count), 8'h4);

        // Overflow on the same edge as clr_ovf: set wins.
        gs = 1'b0; y = 3'b101; clr_ovf = 1'b1;
        tick(VLAT);
        clr_ovf = 1'b0;
        chk("c_set_wins", 8'(ovf), 8'h1);
        chk("c_drop_count", 8'(evt_count), 8'h4);
        gs = 1'b1; y = 3'b111;
        tick(4);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        chk("c_ovf_cleared2", 8'(ovf), 8'h0);

        // Full queue, pop on the same edge as a new push.
        gs = 1'b0; y = 3'b110;
        tick(VLAT - 1);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk("d_count_same", 8'(evt_count), 8'h4);
        chk("d_no_ovf", 8'(ovf), 8'h0);
        chk("d_head_adv", 8'(evt_code), 8'h1);
        gs = 1'b1; y = 3'b111;
        tick(4);
        for (int i = 0; i < 4; i++) begin
            chk("d_drain_code", 8'(evt_code), 8'(drain_exp[i]));
            evt_ready = 1'b1;
            tick(1);
            evt_ready = 1'b0;
        end
        chk("d_drained_valid", 8'(evt_valid), 8'h0);
        chk("d_drained_code", 8'(evt_code), 8'h0);
        evt_ready = 1'b1;
        tick(2);
        evt_ready = 1'b0;
        chk("d_pop_empty_count", 8'(evt_count), 8'h0);

        // Reset mid-request with two entries queued.
        gs = 1'b0; y = 3'b001;
        tick(8);
        y = 3'b010;
        tick(8);
        chk("e_pre_count", 8'(evt_count), 8'h2);
        y = 3'b100;
        tick(4);
        rst = 1'b1;
        #1;
        chk("e_rst_valid", 8'(evt_valid), 8'h0);
        chk("e_rst_count", 8'(evt_count), 8'h0);
        chk("e_rst_ovf", 8'(ovf), 8'h0);
        chk("e_rst_code", 8'(evt_code), 8'h0);
        tick(1);
        rst = 1'b0;
        tick(2);
        chk("e_no_early_push", 8'(evt_count), 8'h0);
        tick(VLAT - 3);
        chk("e_valid_early", 8'(evt_valid), 8'h0);
        tick(1);
        chk("e_valid", 8'(evt_valid), 8'h1);
        chk("e_code", 8'(evt_code), 8'h4);
        tick(10);
        chk("e_single_entry", 8'(evt_count), 8'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/prio_event_capture.md
PRIO_EVENT_CAPTURE -- requirements
Module: prio_event_capture

Interface
REQ-001 Parameter: DEPTH, 4, number of event FIFO entries (power of two, 2..16).
REQ-002 Parameter: DEB_CYCLES, 4, cycles a candidate input must stay stable before qualifying (1..15).
REQ-003 Port: clk  input  1  single system clock, all state on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: y  input  3  encoded request code from the upstream 8-to-3 priority encoder, asynchronous to clk.
REQ-006 Port: gs  input  1  upstream group-select, active-low (0 = a request is present), asynchronous to clk.
REQ-007 Port: evt_code  output  3  code of the FIFO head entry.
REQ-008 Port: evt_valid  output  1  FIFO non-empty.
REQ-009 Port: evt_ready  input  1  consumer accepts the head entry when high with evt_valid.
REQ-010 Port: evt_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-011 Port: ovf  output  1  sticky overflow flag.
REQ-012 Port: clr_ovf  input  1  synchronous clear of ovf.

Function
REQ-013 {gs, y} SHALL pass through a two-flop synchronizer before any other use.
REQ-014 Qualifier FSM states: IDLE (no request), QUAL (candidate counting), ACTIVE (reported request).
REQ-015 IDLE -> QUAL when synchronized gs = 0; candidate code latched, stability counter cleared.
REQ-016 QUAL: counter increments each cycle the synchronized {gs, y} equals the candidate; any difference reloads the candidate and clears the counter; gs = 1 returns to IDLE.
REQ-017 QUAL -> ACTIVE when the counter reaches DEB_CYCLES-1; exactly one push of the candidate code occurs on that transition.
REQ-018 ACTIVE: synchronized gs = 1 -> IDLE; gs = 0 with a code differing from the reported code -> QUAL with the new candidate (a new priority level yields a new event once qualified).
REQ-019 Input-to-push latency SHALL be 2 + DEB_CYCLES cycles for a clean input step; push-to-evt_valid latency SHALL be 1 cycle.
REQ-020 FIFO: push at tail, pop at head when evt_valid & evt_ready; pointers wrap modulo DEPTH.
REQ-021 Push while full with no pop: entry dropped, ovf set next cycle, contents unchanged.
REQ-022 Push and pop in the same cycle when full: both performed, evt_count unchanged, ovf not set.
REQ-023 Pop while empty: ignored.
REQ-024 clr_ovf and a new overflow in the same cycle: ovf remains 1 (set wins).
REQ-025 evt_code SHALL be 3'b000 when evt_valid = 0.

Reset
REQ-026 rst asserted SHALL immediately force FSM = IDLE, synchronizer flops = {gs=1, y=3'b111}, counter = 0, pointers = 0, evt_valid = 0, evt_count = 0, evt_code = 3'b000, ovf = 0.
REQ-027 Reset mid-qualification or with entries queued SHALL discard all pending events; no push occurs within 2 cycles after rst deasserts.

Configuration
REQ-028 Macro PRIO_EVENT_DEBOUNCE_EN defined: qualifier FSM per REQ-014..REQ-018.
REQ-029 Macro undefined: DEB_CYCLES ignored, QUAL state absent, push occurs on the first synchronized cycle that enters or changes an active request (latency 2 + 1 cycles); all other behaviour identical.

Structure
REQ-030 Shared package prio_event_pkg SHALL hold the FSM state enum, the code width constant (3), and the reset/idle code constant 3'b111.
REQ-031 The FIFO SHALL be a separate sub-module prio_event_fifo (parameters DEPTH, WIDTH); synchronizer and FSM stay in the top module.

Verification
REQ-032 gs=0, y=3'b010 held 10 cycles, evt_ready=0, debounce enabled -> single entry, evt_code=3'b010, evt_valid high 7 cycles after input step (2+4+1).
REQ-033 gs toggles 0/1 every 2 cycles for 20 cycles -> no push, evt_count=0.
REQ-034 Five distinct qualified codes 3'b000..3'b100, evt_ready=0 -> evt_count=4, ovf=1, head=3'b000; clr_ovf pulse -> ovf=0.
REQ-035 FIFO full, evt_ready=1 in the same cycle as a fifth push -> evt_count stays 4, ovf stays 0, head advances to 3'b001.
REQ-036 rst pulsed while in QUAL with 2 entries queued -> evt_valid=0, evt_count=0, ovf=0 immediately; held request then re-qualifies and produces one entry.
REQ-037 Macro undefined, gs=0, y=3'b101 one-cycle-clean step -> evt_valid high 3 cycles after the step, evt_code=3'b101.
